// File: rtl/pad_debounce_scheduler.sv
// N-channel pad debouncer: one shared sample prescaler, a channel-sequential scan FSM,
// and a round-robin press/release event queue behind a valid/ready output register.
module pad_debounce_scheduler #(
    parameter int N            = 8,
    parameter int TICK_DIV     = 2700,
    parameter int STABLE_TICKS = 100,
    parameter int CW           = 7
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N-1:0]         noisy,
    output logic [N-1:0]         clean,
    output logic                 event_valid,
    input  logic                 event_ready,
    output logic [$clog2(N)-1:0] event_chan,
    output logic                 event_press,
    output logic                 overflow
);

    localparam int IW = $clog2(N);
    localparam int PW = $clog2(TICK_DIV);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [N-1:0]    sync1_q, sync1_d, sync_q, sync_d;
    logic [N-1:0]    clean_q, clean_d, pending_q, pending_d, dir_q, dir_d;
    logic [CW-1:0]   cnt_q [N];
    logic [CW-1:0]   cnt_d [N];
    logic            overflow_q, overflow_d;
    logic            ev_vld_q, ev_vld_d, ev_press_q, ev_press_d;
    logic [IW-1:0]   ev_chan_q, ev_chan_d, rr_q, rr_d;

    logic            tick, load, sel_found, clr_hit;
    logic [IW-1:0]   sel_ch, cand;
    logic [IW:0]     rr_sum;

    assign tick = (presc_q == PW'(TICK_DIV - 1));
    assign load = !ev_vld_q || event_ready;

    // Walk downward so the last hit is the nearest pending channel at or after rr_q.
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = '0;
        rr_sum    = '0;
        cand      = '0;
        for (int k = N - 1; k >= 0; k--) begin
            rr_sum = {1'b0, rr_q} + (IW + 1)'(k);
            if (rr_sum >= (IW + 1)'(N))
                rr_sum = rr_sum - (IW + 1)'(N);
            cand = rr_sum[IW-1:0];
            if (pending_q[cand]) begin
                sel_found = 1'b1;
                sel_ch    = cand;
            end
        end
    end

    assign clr_hit = load && sel_found && (sel_ch == idx_q);

    always_comb begin
        sync1_d    = noisy;
        sync_d     = sync1_q;
        presc_d    = tick ? '0 : presc_q + 1'b1;
        state_d    = state_q;
        idx_d      = idx_q;
        clean_d    = clean_q;
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        pending_d  = pending_q;
        overflow_d = overflow_q;
        ev_vld_d   = ev_vld_q;
        ev_chan_d  = ev_chan_q;
        ev_press_d = ev_press_q;
        rr_d       = rr_q;

        if (load) begin
            if (sel_found) begin
                ev_vld_d          = 1'b1;
                ev_chan_d         = sel_ch;
                ev_press_d        = dir_q[sel_ch];
                pending_d[sel_ch] = 1'b0;
                rr_d              = (sel_ch == IW'(N - 1)) ? '0 : sel_ch + 1'b1;
            end else begin
                ev_vld_d = 1'b0;
            end
        end

        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                if (sync_q[idx_q] == clean_q[idx_q]) begin
                    cnt_d[idx_q] = '0;
                end else if (cnt_q[idx_q] + 1'b1 == CW'(STABLE_TICKS)) begin
                    clean_d[idx_q] = sync_q[idx_q];
                    dir_d[idx_q]   = sync_q[idx_q];
                    cnt_d[idx_q]   = '0;
                    // A set racing the loader's clear is a fresh event, not a merge.
                    if (pending_q[idx_q] && !clr_hit)
                        overflow_d = 1'b1;
                    pending_d[idx_q] = 1'b1;
                end else begin
                    cnt_d[idx_q] = cnt_q[idx_q] + 1'b1;
                end
                if (idx_q == IW'(N - 1)) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            presc_q    <= '0;
            sync1_q    <= '0;
            sync_q     <= '0;
            clean_q    <= '0;
            cnt_q      <= '{default: '0};
            dir_q      <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            ev_vld_q   <= 1'b0;
            ev_chan_q  <= '0;
            ev_press_q <= 1'b0;
            rr_q       <= '0;
        end else begin
            assert (!(tick && state_q == SCAN));
            state_q    <= state_d;
            idx_q      <= idx_d;
            presc_q    <= presc_d;
            sync1_q    <= sync1_d;
            sync_q     <= sync_d;
            clean_q    <= clean_d;
            cnt_q      <= cnt_d;
            dir_q      <= dir_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            ev_vld_q   <= ev_vld_d;
            ev_chan_q  <= ev_chan_d;
            ev_press_q <= ev_press_d;
            rr_q       <= rr_d;
        end
    end

    assign clean       = clean_q;
    assign event_valid = ev_vld_q;
    assign event_chan  = ev_chan_q;
    assign event_press = ev_press_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_pad_debounce_scheduler.sv
// Directed bench for pad_debounce_scheduler (N=4, TICK_DIV=8, STABLE_TICKS=3) with an event scoreboard.
module tb_pad_debounce_scheduler;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] noisy = '0;
    logic       event_ready = 1'b0;
    logic [3:0] clean;
    logic       event_valid;
    logic [1:0] event_chan;
    logic       event_press;
    logic       overflow;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    logic [2:0] sb[$];

    pad_debounce_scheduler #(
        .N(4), .TICK_DIV(8), .STABLE_TICKS(3), .CW(2)
    ) dut (
        .clock(clock), .reset(reset), .noisy(noisy), .clean(clean),
        .event_valid(event_valid), .event_ready(event_ready),
        .event_chan(event_chan), .event_press(event_press), .overflow(overflow)
    );

    always #5 clock = ~clock;

    // Cycles since reset release; equals the DUT prescaler phase.
    always @(posedge clock) cyc <= reset ? 0 : cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic mon();
        logic [2:0] e;
        if (!reset && event_valid && event_ready) begin
            n_vec++;
            assert (sb.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_event observed chan=%0d press=%0d expected none (cyc %0d)",
                       event_chan, event_press, cyc);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("event", 32'({event_chan, event_press}), 32'(e));
            end
        end
    endtask

    task automatic step();
        @(negedge clock);
        mon();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_cyc(input int k);
        int g = 0;
        while (cyc != k && g < 2000) begin
            step();
            g++;
        end
        if (cyc != k) check("wait_cyc", 32'(cyc), 32'(k));
    endtask

    task automatic drain(input string tag);
        int g = 0;
        while (sb.size() != 0 && g < 300) begin
            step();
            g++;
        end
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_clean"}, 32'(clean), 32'd0);
        check({tag, "_out"}, 32'({event_valid, event_chan, event_press, overflow}), 32'd0);
    endtask

    task automatic do_reset(input logic [3:0] nv, input logic rdy);
        reset       = 1'b1;
        noisy       = nv;
        event_ready = rdy;
        sb.delete();
        step();
        step();
        check_zero("reset");
        reset = 1'b0;
    endtask

    initial begin
        // Power-up with all pads held: four presses in channel order.
        do_reset(4'hF, 1'b1);
        for (int i = 0; i < 4; i++) sb.push_back({2'(i), 1'b1});
        for (int g = 0; g < 30 && clean !== 4'hF; g++) step();
        check("t1_clean", 32'(clean), 32'hF);
        drain("t1_drain");
        check("t1_ovf", 32'(overflow), 32'd0);

        // Bounce on channel 1: only the final level counts.
        do_reset(4'h0, 1'b1);
        wait_cyc(12); noisy = 4'b0010;
        wait_cyc(20); noisy = 4'b0000;
        wait_cyc(28); noisy = 4'b0010;
        wait_cyc(49);
        check("t2_clean_before", 32'(clean), 32'h0);
        check("t2_no_event", 32'(event_valid), 32'd0);
        sb.push_back({2'd1, 1'b1});
        step();
        check("t2_clean_after", 32'(clean), 32'h2);
        drain("t2_drain");
        repeat (20) step();

        // Backpressure: channel 0 held while channel 2 waits.
        do_reset(4'h0, 1'b0);
        wait_cyc(4); noisy = 4'b0101;
        for (int g = 0; g < 40 && event_valid !== 1'b1; g++) step();
        for (int h = 0; h < 50; h++) begin
            check("t3_hold", 32'({event_valid, event_chan, event_press}), 32'b1001);
            step();
        end
        sb.push_back({2'd0, 1'b1});
        sb.push_back({2'd2, 1'b1});
        event_ready = 1'b1;
        drain("t3_drain");

        // Round robin from rr_ptr=2 with all channels pending.
        do_reset(4'h0, 1'b0);
        wait_cyc(4); noisy = 4'b0010;
        wait_cyc(36);
        check("t4_held", 32'({event_valid, event_chan, event_press}), 32'b1011);
        noisy = 4'b1101;
        wait_cyc(62);
        check("t4_clean", 32'(clean), 32'hD);
        check("t4_ovf", 32'(overflow), 32'd0);
        sb.push_back({2'd1, 1'b1});
        sb.push_back({2'd2, 1'b1});
        sb.push_back({2'd3, 1'b1});
        sb.push_back({2'd0, 1'b1});
        sb.push_back({2'd1, 1'b0});
        event_ready = 1'b1;
        drain("t4_drain");

        // Overflow: channel 3 press then release merge behind a held channel 0 event.
        do_reset(4'h0, 1'b0);
        wait_cyc(4); noisy = 4'b0001;
        wait_cyc(36); noisy = 4'b1001;
        wait_cyc(68);
        check("t5_ovf_before", 32'(overflow), 32'd0);
        noisy = 4'b0001;
        wait_cyc(94);
        check("t5_ovf_after", 32'(overflow), 32'd1);
        check("t5_clean", 32'(clean), 32'h1);
        check("t5_held", 32'({event_valid, event_chan, event_press}), 32'b1001);
        sb.push_back({2'd0, 1'b1});
        sb.push_back({2'd3, 1'b0});
        event_ready = 1'b1;
        drain("t5_drain");
        repeat (40) step();
        check("t5_ovf_sticky", 32'(overflow), 32'd1);
        check("t5_idle", 32'(event_valid), 32'd0);

        // Reset while the scan is on channel 2.
        do_reset(4'hF, 1'b1);
        wait_cyc(26);
        check("t6_clean_pre", 32'(clean), 32'h3);
        reset = 1'b1;
        noisy = 4'h0;
        step();
        check_zero("t6_rst");
        reset = 1'b0;
        repeat (60) step();
        check("t6_idle", 32'(event_valid), 32'd0);
        check("t6_clean", 32'(clean), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
